// File: rtl/tagger_cfg_sequencer.sv
// tagger_cfg_sequencer
// Autonomous RegBus master that programs the tagger partition configuration
// registers from a locally held entry table. On start_i it writes every ADDR
// register, then every PATID register, then every CONF register, then COMMIT.
// A bus error on any handshake aborts the sequence (COMMIT is skipped).
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   load_valid_i/ready_o     table write handshake (ready = !busy_o)
//   load_idx_i/addr_i/patid_i/mode_i   entry index and fields
//   start_i                  begin a programming sequence (IDLE only)
//   busy_o, done_o, error_o  status: in progress, end pulse, sticky abort flag
//   cfg_req_o / cfg_rsp_i    RegBus master port toward tagger cfg port

package tagger_cfg_sequencer_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;
endpackage

module tagger_cfg_sequencer #(
  parameter int unsigned MAXPARTITION = 8,
  parameter type reg_req_t = tagger_cfg_sequencer_pkg::reg_req_t,
  parameter type reg_rsp_t = tagger_cfg_sequencer_pkg::reg_rsp_t,
  localparam int unsigned IDXW = $clog2(MAXPARTITION)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_valid_i,
  output logic            load_ready_o,
  input  logic [IDXW-1:0] load_idx_i,
  input  logic [31:0]     load_addr_i,
  input  logic [3:0]      load_patid_i,
  input  logic [1:0]      load_mode_i,
  input  logic            start_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            error_o,
  output reg_req_t        cfg_req_o,
  input  reg_rsp_t        cfg_rsp_i
);

  localparam int unsigned NPATID = MAXPARTITION / 8;
  localparam int unsigned NCONF  = (MAXPARTITION + 15) / 16;
  localparam logic [31:0] ADDR_BASE  = 32'h0000_0004;
  localparam logic [31:0] PATID_BASE = 32'(4 + 4 * MAXPARTITION);
  localparam logic [31:0] CONF_BASE  = 32'(4 + 4 * MAXPARTITION + 4 * NPATID);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_ADDR   = 3'd1,
    WR_PATID  = 3'd2,
    WR_CONF   = 3'd3,
    WR_COMMIT = 3'd4,
    FINISH    = 3'd5
  } state_e;

  state_e          state_r, state_next_s;
  logic [IDXW-1:0] idx_r, idx_next_s;
  logic            busy_r, done_r, error_r, error_next_s;
  reg_req_t        req_s;

  logic [31:0] addr_tbl_r  [MAXPARTITION];
  logic [3:0]  patid_tbl_r [MAXPARTITION];
  logic [1:0]  mode_tbl_r  [MAXPARTITION];

  // Read data is never needed; fold it into a sink so it is visibly consumed.
  logic rsp_unused_s;
  assign rsp_unused_s = ^cfg_rsp_i.rdata;

  assign load_ready_o = ~busy_r;
  assign busy_o       = busy_r;
  assign done_o       = done_r;
  assign error_o      = error_r;
  assign cfg_req_o    = req_s;

  // Entry table: written only while idle, cleared by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(MAXPARTITION); i++) begin
        addr_tbl_r[i]  <= 32'd0;
        patid_tbl_r[i] <= 4'd0;
        mode_tbl_r[i]  <= 2'd0;
      end
    end else if (load_valid_i && !busy_r) begin
      addr_tbl_r[load_idx_i]  <= load_addr_i;
      patid_tbl_r[load_idx_i] <= load_patid_i;
      mode_tbl_r[load_idx_i]  <= load_mode_i;
    end
  end

  // Sequencer state, write index and registered status outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
      idx_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      error_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      idx_r   <= idx_next_s;
      busy_r  <= (state_next_s != IDLE);
      done_r  <= (state_next_s == FINISH);
      error_r <= error_next_s;
    end
  end

  // Next-state: advance on handshake, abort straight to FINISH on bus error.
  always_comb begin
    logic [IDXW-1:0] last_idx_s;
    state_e          after_s;
    state_next_s = state_r;
    idx_next_s   = idx_r;
    error_next_s = error_r;
    last_idx_s   = IDXW'(NCONF - 1);
    after_s      = WR_COMMIT;
    case (state_r)
      WR_ADDR: begin
        last_idx_s = IDXW'(MAXPARTITION - 1);
        after_s    = WR_PATID;
      end
      WR_PATID: begin
        last_idx_s = IDXW'(NPATID - 1);
        after_s    = WR_CONF;
      end
      default: begin
        last_idx_s = IDXW'(NCONF - 1);
        after_s    = WR_COMMIT;
      end
    endcase
    case (state_r)
      IDLE: begin
        if (start_i) begin
          state_next_s = WR_ADDR;
          idx_next_s   = '0;
          error_next_s = 1'b0;
        end else begin
          state_next_s = IDLE;
        end
      end
      WR_ADDR, WR_PATID, WR_CONF: begin
        if (!cfg_rsp_i.ready) begin
          state_next_s = state_r;
        end else if (cfg_rsp_i.error) begin
          error_next_s = 1'b1;
          state_next_s = FINISH;
        end else if (idx_r == last_idx_s) begin
          state_next_s = after_s;
          idx_next_s   = '0;
        end else begin
          idx_next_s = idx_r + IDXW'(1'b1);
        end
      end
      WR_COMMIT: begin
        if (cfg_rsp_i.ready) begin
          error_next_s = cfg_rsp_i.error;
          state_next_s = FINISH;
        end else begin
          state_next_s = WR_COMMIT;
        end
      end
      FINISH: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
        idx_next_s   = '0;
      end
    endcase
  end

  // Request decode from registered state/index; the table cannot change while
  // busy, so addr/wdata stay stable until the handshake.
  always_comb begin
    logic [31:0] ent_s;
    req_s = '0;
    ent_s = 32'd0;
    case (state_r)
      WR_ADDR: begin
        req_s.valid = 1'b1;
        req_s.addr  = ADDR_BASE + (32'(idx_r) << 2);
        req_s.wdata = addr_tbl_r[idx_r];
      end
      WR_PATID: begin
        req_s.valid = 1'b1;
        req_s.addr  = PATID_BASE + (32'(idx_r) << 2);
        for (int k = 0; k < 8; k++) begin
          ent_s = (32'(idx_r) << 3) + 32'(k);
          req_s.wdata[4*k +: 4] = patid_tbl_r[ent_s[IDXW-1:0]];
        end
      end
      WR_CONF: begin
        req_s.valid = 1'b1;
        req_s.addr  = CONF_BASE + (32'(idx_r) << 2);
        // Last CONF word may be partially populated; missing slots read 0.
        for (int k = 0; k < 16; k++) begin
          ent_s = (32'(idx_r) << 4) + 32'(k);
          if (ent_s < 32'(MAXPARTITION)) begin
            req_s.wdata[2*k +: 2] = mode_tbl_r[ent_s[IDXW-1:0]];
          end else begin
            req_s.wdata[2*k +: 2] = 2'd0;
          end
        end
      end
      WR_COMMIT: begin
        req_s.valid = 1'b1;
        req_s.addr  = 32'h0000_0000;
        req_s.wdata = 32'h0000_0001;
      end
      default: begin
        req_s = '0;
      end
    endcase
    if (req_s.valid) begin
      req_s.write = 1'b1;
      req_s.wstrb = 4'hF;
    end else begin
      req_s.write = 1'b0;
      req_s.wstrb = 4'h0;
    end
  end

endmodule

// File: doc/tagger_cfg_sequencer.md
Name: tagger_cfg_sequencer

Overview:
Autonomous RegBus master that programs the `tagger` partition configuration registers from a locally held entry table.
- On `start_i` it writes, in fixed order, every address register, then every patid register, then every conf register, then the commit register.
- Sits between a host-side control port (boot FSM, debug module or CSR shim) and the `cfg_req_i`/`cfg_rsp_o` port of `tagger`.
- Reports completion and bus errors to the host.

Parameters:
- MAXPARTITION, 8, number of partition entries; must be a multiple of 8 and ≥8.
- reg_req_t, logic, RegBus request struct with fields addr[31:0], write, wdata[31:0], wstrb[3:0], valid.
- reg_rsp_t, logic, RegBus response struct with fields rdata[31:0], error, ready.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- load_valid_i  in  1  write one table entry this cycle.
- load_ready_o  out  1  table writable; equals !busy_o.
- load_idx_i  in  $clog2(MAXPARTITION)  entry index.
- load_addr_i  in  32  address word, already shifted >>2 by the host.
- load_patid_i  in  4  partition ID.
- load_mode_i  in  2  0=off, 1=TOR, 3=NAPOT.
- start_i  in  1  begin a programming sequence.
- busy_o  out  1  sequence in progress.
- done_o  out  1  one-cycle pulse at end of sequence.
- error_o  out  1  sticky: last sequence aborted on a bus error.
- cfg_req_o  out  reg_req_t  to `tagger` cfg port.
- cfg_rsp_i  in  reg_rsp_t  from `tagger` cfg port.

Behaviour:
- Reset values: table entries all 0; state IDLE; busy_o=0, done_o=0, error_o=0, cfg_req_o all-zero (valid=0); write index 0.
- Reset asserted mid-sequence: immediate return to reset values; the partial sequence is dropped and no commit is issued.
- Table load:
  - A load is accepted when load_valid_i & load_ready_o; the entry is written on that clock edge.
  - Loads while busy are ignored; the table is unchanged.
- Register map (byte addresses; wstrb always 4'hF; write=1):
  - ADDR[i] = 0x04+4i, i<M (M = MAXPARTITION); wdata = entry[i].addr.
  - PATID[j] = 0x04+4M+4j, j<M/8; wdata bits [4k+3:4k] = entry[8j+k].patid.
  - CONF[j] = 0x04+4M+4(M/8)+4j, j<ceil(M/16); wdata bits [2k+1:2k] = entry[16j+k].mode; unused bits 0.
  - COMMIT = 0x00, wdata = 32'h1.
  - For M=8: ADDR 0x04..0x20, PATID 0x24, CONF 0x28, COMMIT 0x00.
  - Total writes N = M + M/8 + ceil(M/16) + 1; for M=8, N=11.
- FSM states IDLE → WR_ADDR → WR_PATID → WR_CONF → WR_COMMIT → FINISH → IDLE:
  - IDLE: start_i=1 moves to WR_ADDR and clears error_o. Valid is asserted from the next cycle.
  - start_i=1 together with load_valid_i=1 in IDLE: the load is written first, and the sequence uses the updated table.
  - Each write state: valid=1 with addr/wdata stable until the cycle where ready=1 (the handshake).
    - Handshake with error=0: advance the index/state. The next write may be presented in the very next cycle; valid stays high and back-to-back transfers are allowed.
    - Handshake with error=1: set error_o, skip all remaining writes including COMMIT, go to FINISH.
  - FINISH: valid=0, done_o=1 for exactly one cycle, busy_o=0 from the next cycle, return to IDLE.
  - busy_o=1 in every state except IDLE.
  - start_i outside IDLE is ignored.
  - The table is read combinationally during the sequence and is immutable while busy.
- Latency: with ready tied high, start at cycle 0 gives valid cycles 1..N and done_o at cycle N+1. For M=8, done_o is at cycle 12.
- cfg_req_o.valid never drops before its handshake; no read transactions are ever issued.

Test Plan:
- NAPOT: load entries i=0..7 with patid=i, mode=3 for i<4 else 0, addr[0]=(0x2000_0000+0x07FF_FFFF)>>2=0x09FF_FFFF; start with ready=1 → 11 writes in order 0x04..0x20, 0x24=0x7654_3210, 0x28=0x0000_00FF, 0x00=0x1; done_o at cycle 12; error_o=0.
- TOR: addr[i]=(0x2000_0000·(i+1))>>2 for i<4, patid=7-i for all 8 entries, mode=1 for i<4 → 0x24=0x0123_4567, 0x28=0x0000_0055, commit issued last.
- Backpressure: hold ready=0 for 5 cycles on the 0x24 write → addr/wdata/valid stable for all 5 cycles; sequence completes after; done_o delayed by 5 cycles.
- Bus error: error=1 on the handshake of the 3rd write (0x0C) → no further valid, no write to 0x00, done_o pulses, error_o=1 until the next start_i.
- Ignored inputs: load_valid_i and start_i pulsed during the sequence → table unchanged (next run reproduces the same wdata), only one done_o.
- Mid-sequence reset: assert rst_ni low after 4 writes → valid=0 immediately, busy_o=0, table cleared; after release, start writes all-zero entries and commit.
